// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// The RegDst codes must stay in step with the datapath's write-back select encoding.
package hazard_ctrl_pkg;

  localparam logic [1:0] REGDST_FROM_ALU = 2'd0;
  localparam logic [1:0] REGDST_FROM_MEM = 2'd1;
  localparam logic [1:0] REGDST_FROM_PC  = 2'd2;

  typedef enum logic [1:0] {
    HC_RUN      = 2'd0,
    HC_MEM_WAIT = 2'd1,
    HC_DRAIN    = 2'd2,
    HC_HALTED   = 2'd3
  } hc_state_e;

  typedef struct packed {
    logic pc_wr_en;
    logic pc_sel_redirect;
    logic ifid_wr_en;
    logic ifid_flush;
    logic idex_wr_en;
    logic idex_bubble;
    logic exmem_wr_en;
    logic memwb_bubble;
  } hc_ctrl_t;

  localparam hc_ctrl_t CTRL_IDLE     = hc_ctrl_t'(8'b0000_0000);
  localparam hc_ctrl_t CTRL_RUN      = hc_ctrl_t'(8'b1010_1010);
  localparam hc_ctrl_t CTRL_FREEZE   = hc_ctrl_t'(8'b0000_0001);
  localparam hc_ctrl_t CTRL_REDIRECT = hc_ctrl_t'(8'b1111_1110);
  localparam hc_ctrl_t CTRL_STALL    = hc_ctrl_t'(8'b0000_1110);
  localparam hc_ctrl_t CTRL_DRAIN    = hc_ctrl_t'(8'b0011_1010);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard sources in, stage enables and counters out.
// master = pipeline side, slave = controller side.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_valid;
  logic             ex_regwr;
  logic [1:0]       ex_regdst;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             dmem_busy;
  logic             halt_req;
  logic             resume;

  logic             pc_wr_en;
  logic             pc_sel_redirect;
  logic             ifid_wr_en;
  logic             ifid_flush;
  logic             idex_wr_en;
  logic             idex_bubble;
  logic             exmem_wr_en;
  logic             memwb_bubble;
  logic             halted;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_regwr, ex_regdst,
           ex_rd, ex_redirect, dmem_busy, halt_req, resume,
    input  pc_wr_en, pc_sel_redirect, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble,
           exmem_wr_en, memwb_bubble, halted, err_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_valid, ex_regwr, ex_regdst,
           ex_rd, ex_redirect, dmem_busy, halt_req, resume,
    output pc_wr_en, pc_sel_redirect, ifid_wr_en, ifid_flush, idex_wr_en, idex_bubble,
           exmem_wr_en, memwb_bubble, halted, err_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use detector: a load in EX whose result the ID instruction needs cannot be
// forwarded in time, so the consumer must wait one cycle.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_regwr,
  input  logic [1:0] i_ex_regdst,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  output logic       o_load_use
);
  logic w_ex_load;
  logic w_src_hit;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_ex_load  = i_ex_valid & i_ex_regwr & (i_ex_regdst == REGDST_FROM_MEM) & (i_ex_rd != 5'd0);
  assign w_src_hit  = (i_id_use_rs1 & (i_ex_rd == i_id_rs1)) | (i_id_use_rs2 & (i_ex_rd == i_id_rs2));
  assign o_load_use = w_ex_load & w_src_hit;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble generation, data-memory wait
// freeze, halt/drain/resume FSM and perf counters. Controls are same-cycle combinational.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_WAIT     = 255,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int WAIT_W  = $clog2(MAX_WAIT + 2);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  hc_state_e          r_state, w_state_next, r_ret, w_ret_next, w_eval_state;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_next;
  logic [DRAIN_W-1:0] r_drain_cnt, w_drain_next;
  logic               r_err, w_err_next;
  logic [CNT_W-1:0]   r_stall_cnt, w_stall_next, r_flush_cnt, w_flush_next;
  hc_ctrl_t           w_ctrl, w_ctrl_out;
  logic               w_load_use;

  hazard_detect u_detect (
    .i_ex_valid   (bus.ex_valid),
    .i_ex_regwr   (bus.ex_regwr),
    .i_ex_regdst  (bus.ex_regdst),
    .i_ex_rd      (bus.ex_rd),
    .i_id_rs1     (bus.id_rs1),
    .i_id_rs2     (bus.id_rs2),
    .i_id_use_rs1 (bus.id_use_rs1),
    .i_id_use_rs2 (bus.id_use_rs2),
    .o_load_use   (w_load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HC_RUN;
      r_ret       <= HC_RUN;
      r_wait_cnt  <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ret       <= w_ret_next;
      r_wait_cnt  <= w_wait_next;
      r_drain_cnt <= w_drain_next;
      r_err       <= w_err_next;
      r_stall_cnt <= w_stall_next;
      r_flush_cnt <= w_flush_next;
    end
  end

  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_state_next = r_state;
    w_ret_next   = r_ret;
    w_wait_next  = r_wait_cnt;
    w_drain_next = r_drain_cnt;
    w_err_next   = r_err;
    w_stall_next = r_stall_cnt;
    w_flush_next = r_flush_cnt;
    w_eval_state = r_state;

    // Memory wait ending: the saved state's rules apply in this very cycle
    if (r_state == HC_MEM_WAIT && !bus.dmem_busy) begin
      w_eval_state = r_ret;
      w_state_next = r_ret;
    end

    case (w_eval_state)
      HC_RUN: begin
        if (bus.dmem_busy) begin
          w_ctrl       = CTRL_FREEZE;
          w_state_next = HC_MEM_WAIT;
          w_ret_next   = HC_RUN;
          w_wait_next  = WAIT_W'(1);
          if (WAIT_W'(1) >= WAIT_LIMIT) w_err_next = 1'b1;
        end else if (bus.ex_redirect) begin
          w_ctrl       = CTRL_REDIRECT;
          w_flush_next = r_flush_cnt + CNT_W'(1);
        end else if (w_load_use) begin
          w_ctrl       = CTRL_STALL;
          w_stall_next = r_stall_cnt + CNT_W'(1);
        end else if (bus.halt_req) begin
          w_ctrl       = CTRL_DRAIN;
          w_state_next = HC_DRAIN;
          w_drain_next = '0;
        end
      end
      HC_MEM_WAIT: begin
        w_ctrl = CTRL_FREEZE;
        if (r_wait_cnt != '1) w_wait_next = r_wait_cnt + WAIT_W'(1);
        if (w_wait_next >= WAIT_LIMIT) w_err_next = 1'b1;
      end
      HC_DRAIN: begin
        if (bus.dmem_busy) begin
          w_ctrl       = CTRL_FREEZE;
          w_state_next = HC_MEM_WAIT;
          w_ret_next   = HC_DRAIN;
          w_wait_next  = WAIT_W'(1);
          if (WAIT_W'(1) >= WAIT_LIMIT) w_err_next = 1'b1;
        end else begin
          w_ctrl = CTRL_DRAIN;
          if (r_drain_cnt == DRAIN_LAST) w_state_next = HC_HALTED;
          else                           w_drain_next = r_drain_cnt + DRAIN_W'(1);
        end
      end
      HC_HALTED: begin
        w_ctrl = CTRL_IDLE;
        if (bus.resume) w_state_next = HC_RUN;
      end
      default: w_state_next = HC_RUN;
    endcase
  end

  assign w_ctrl_out = rst_n ? w_ctrl : CTRL_IDLE;

  assign bus.pc_wr_en        = w_ctrl_out.pc_wr_en;
  assign bus.pc_sel_redirect = w_ctrl_out.pc_sel_redirect;
  assign bus.ifid_wr_en      = w_ctrl_out.ifid_wr_en;
  assign bus.ifid_flush      = w_ctrl_out.ifid_flush;
  assign bus.idex_wr_en      = w_ctrl_out.idex_wr_en;
  assign bus.idex_bubble     = w_ctrl_out.idex_bubble;
  assign bus.exmem_wr_en     = w_ctrl_out.exmem_wr_en;
  assign bus.memwb_bubble    = w_ctrl_out.memwb_bubble;
  assign bus.halted          = (r_state == HC_HALTED);
  assign bus.err_timeout     = r_err;
  assign bus.stall_cnt       = r_stall_cnt;
  assign bus.flush_cnt       = r_flush_cnt;
endmodule
